// File: rtl/sar_pkg.sv
// Shared types, default sizing and mask helper for the SAR ADC sequencer.
package sar_pkg;

  typedef enum logic [1:0] {IDLE, SAMPLE, TRIAL, DONE} state_t;

  localparam int DEF_NBITS         = 10;
  localparam int DEF_SAMPLE_CYCLES = 2;
  localparam int DEF_SETTLE_CYCLES = 2;
  localparam int MASK_W            = 32;

  // One-hot mask for bit position idx; out-of-range positions yield zero
  // rather than wrapping.
  function automatic logic [MASK_W-1:0] bit_mask(input int unsigned idx);
    logic [MASK_W-1:0] one;
    one = MASK_W'(1);
    return (idx < MASK_W) ? (one << idx) : '0;
  endfunction

endpackage

// File: rtl/sar_edge_detect.sv
// Registered rising-edge detector; rise is high for the single clk cycle
// in which sig is 1 and its previous-cycle copy was 0.
module sar_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic sig,
  output logic rise
);

  logic prev;

  always_ff @(posedge clk) begin
    if (!reset) prev <= 1'b0;
    else        prev <= sig;
  end

  assign rise = sig & ~prev;

endmodule

// File: rtl/sar_adc_controller.sv
// Successive-approximation sequencer: track phase, one MSB-first trial per
// bit, result delivered over a valid/ready handshake.
module sar_adc_controller
  import sar_pkg::*;
#(
  parameter int NBITS         = DEF_NBITS,
  parameter int SAMPLE_CYCLES = DEF_SAMPLE_CYCLES,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sys_clk,
  input  logic             auto_en,
  input  logic             start,
  input  logic             comp_out,
  output logic             sample_en,
  output logic [NBITS-1:0] dac_code,
  output logic             busy,
  output logic [NBITS-1:0] result,
  output logic             result_valid,
  input  logic             result_ready,
  output logic             overrun
);

  localparam int IW   = (NBITS > 1) ? $clog2(NBITS) : 1;
  localparam int CMAX = (SAMPLE_CYCLES > SETTLE_CYCLES) ? SAMPLE_CYCLES : SETTLE_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [IW-1:0]    idx;
  logic             sys_rise, trigger, handshake, accept;
  logic [NBITS-1:0] cur_mask, next_mask, kept;

  sar_edge_detect u_edge (
    .clk   (clk),
    .reset (reset),
    .sig   (sys_clk),
    .rise  (sys_rise)
  );

  assign trigger   = start | (auto_en & sys_rise);
  assign handshake = result_valid & result_ready;
  assign accept    = (state == IDLE) & trigger & (~result_valid | result_ready);

  assign cur_mask  = NBITS'(bit_mask(32'(idx)));
  assign next_mask = NBITS'(bit_mask(32'(idx) - 32'd1));
  // The DAC code under test doubles as the trial register: dropping the
  // current bit on a low comparator decision leaves only the kept bits.
  assign kept      = comp_out ? dac_code : (dac_code & ~cur_mask);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= IDLE;
      cnt          <= '0;
      idx          <= '0;
      sample_en    <= 1'b0;
      dac_code     <= '0;
      busy         <= 1'b0;
      result       <= '0;
      result_valid <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      if (handshake)          result_valid <= 1'b0;
      if (trigger && !accept) overrun      <= 1'b1;

      case (state)
        IDLE: begin
          if (accept) begin
            state     <= SAMPLE;
            sample_en <= 1'b1;
            busy      <= 1'b1;
            cnt       <= CW'(SAMPLE_CYCLES - 1);
          end
        end
        SAMPLE: begin
          if (cnt == '0) begin
            sample_en <= 1'b0;
            idx       <= IW'(NBITS - 1);
            dac_code  <= NBITS'(bit_mask(NBITS - 1));
            cnt       <= CW'(SETTLE_CYCLES - 1);
            state     <= TRIAL;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        TRIAL: begin
          if (cnt == '0) begin
            if (idx != '0) begin
              idx      <= idx - IW'(1);
              dac_code <= kept | next_mask;
              cnt      <= CW'(SETTLE_CYCLES - 1);
            end else begin
              dac_code     <= kept;
              result       <= kept;
              result_valid <= 1'b1;
              state        <= DONE;
            end
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        DONE: begin
          busy     <= 1'b0;
          dac_code <= '0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sar_adc_controller.sv
// Scoreboard bench: ideal comparator model, expected codes queued at trigger
// time and compared when the converter reports a result.
module tb_sar_adc_controller;

  logic       clk = 0;
  logic       reset;
  logic       sys_clk, auto_en, start, result_ready;
  logic [9:0] vin;
  logic       comp_out, sample_en, busy, result_valid, overrun;
  logic [9:0] dac_code, result;

  logic       start2, ready2;
  logic [5:0] vin2, dac2, result2;
  logic       comp2, sample2, busy2, valid2, overrun2;
  logic       sys_clk2 = 1'b0;
  logic       auto2 = 1'b0;

  int checks = 0;
  int failures = 0;
  logic [9:0] sb[$];
  logic [5:0] sb2[$];

  always #5 clk = ~clk;

  assign comp_out = (vin >= dac_code);
  assign comp2    = (vin2 >= dac2);

  sar_adc_controller dut (
    .clk(clk), .reset(reset), .sys_clk(sys_clk), .auto_en(auto_en),
    .start(start), .comp_out(comp_out), .sample_en(sample_en),
    .dac_code(dac_code), .busy(busy), .result(result),
    .result_valid(result_valid), .result_ready(result_ready), .overrun(overrun)
  );

  sar_adc_controller #(.NBITS(6), .SAMPLE_CYCLES(1), .SETTLE_CYCLES(1)) dut2 (
    .clk(clk), .reset(reset), .sys_clk(sys_clk2), .auto_en(auto2),
    .start(start2), .comp_out(comp2), .sample_en(sample2),
    .dac_code(dac2), .busy(busy2), .result(result2),
    .result_valid(valid2), .result_ready(ready2), .overrun(overrun2)
  );

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 0; start = 0; auto_en = 0; sys_clk = 0; result_ready = 1; vin = 0;
    start2 = 0; ready2 = 1; vin2 = 0;
    step(); step();
    checks++; if ({sample_en, busy, result_valid, overrun} !== 4'b0) begin
      failures++; $display("FAIL reset_flags got=%b exp=0000", {sample_en, busy, result_valid, overrun}); end
    checks++; if (dac_code !== 10'd0 || result !== 10'd0) begin
      failures++; $display("FAIL reset_codes got dac=%0d res=%0d exp 0 0", dac_code, result); end
    checks++; if ({sample2, busy2, valid2, overrun2} !== 4'b0 || dac2 !== 6'd0 || result2 !== 6'd0) begin
      failures++; $display("FAIL reset_small got flags=%b dac=%0d", {sample2, busy2, valid2, overrun2}, dac2); end
    reset = 1;
    step();
  endtask

  // Start one conversion with a start pulse; optionally check the trial
  // sequence and/or pulse a dropped start at cycle pulse_at.
  task automatic run_conv(input int v, input bit chk_seq, input int pulse_at);
    int n;
    logic [9:0] seq[$];
    logic [9:0] exp_seq[10] = '{512, 256, 384, 320, 352, 336, 344, 340, 342, 341};
    logic [9:0] e;
    vin = 10'(v); start = 1; sb.push_back(10'(v));
    step(); start = 0; n = 1;
    while (!result_valid && n < 200) begin
      if (n <= 3) begin
        checks++; if (sample_en !== (n <= 2)) begin
          failures++; $display("FAIL sample_en_c%0d got=%b exp=%b", n, sample_en, (n <= 2)); end
      end
      if (n >= 3 && ((n - 3) % 2) == 0) seq.push_back(dac_code);
      start = (n == pulse_at);
      step(); n++;
    end
    start = 0;
    checks++;
    if (!result_valid) begin
      failures++; $display("FAIL conv_timeout vin=%0d got no result exp result", v);
    end else begin
      e = sb.pop_front();
      if (result !== e) begin failures++; $display("FAIL conv_result got=%0d exp=%0d", result, e); end
      checks++; if (n != 23) begin failures++; $display("FAIL conv_latency got=%0d exp=23", n); end
    end
    if (chk_seq) begin
      checks++;
      if (seq.size() != 10) begin
        failures++; $display("FAIL dac_seq_len got=%0d exp=10", seq.size());
      end else begin
        foreach (exp_seq[i]) if (seq[i] !== exp_seq[i]) begin
          failures++; $display("FAIL dac_seq_%0d got=%0d exp=%0d", i, seq[i], exp_seq[i]); break; end
      end
    end
    step();
    checks++; if (result_valid !== 1'b0 || busy !== 1'b0 || dac_code !== 10'd0) begin
      failures++; $display("FAIL post_conv got valid=%b busy=%b dac=%0d exp 0 0 0", result_valid, busy, dac_code); end
    step();
  endtask

  task automatic test_codes();
    run_conv(512, 0, 0);
    run_conv(0, 0, 0);
    run_conv(1023, 0, 0);
    run_conv(341, 1, 0);
  endtask

  task automatic test_auto();
    logic [9:0] vals[3] = '{100, 900, 555};
    logic [9:0] e, held;
    int k = 0;
    int got = 0;
    auto_en = 1; result_ready = 1; sys_clk = 0;
    for (int c = 0; c < 120; c++) begin
      if (c % 40 == 0) begin sys_clk = 1; vin = vals[k]; sb.push_back(vals[k]); k++; end
      if (c % 40 == 20) sys_clk = 0;
      step();
      if (result_valid) begin
        got++; checks++;
        if (sb.size() == 0) begin failures++; $display("FAIL auto_unexpected got=%0d exp none", result); end
        else begin e = sb.pop_front();
          if (result !== e) begin failures++; $display("FAIL auto_result got=%0d exp=%0d", result, e); end end
      end
    end
    checks++; if (got != 3 || overrun !== 1'b0) begin
      failures++; $display("FAIL auto_count got=%0d ovr=%b exp 3 0", got, overrun); end
    result_ready = 0;
    for (int c = 0; c < 80; c++) begin
      if (c == 0)  begin sys_clk = 1; vin = 10'd250; sb.push_back(10'd250); end
      if (c == 40) begin sys_clk = 1; vin = 10'd600; end
      if (c % 40 == 20) sys_clk = 0;
      step();
    end
    e = sb.pop_front(); held = result;
    checks++; if (result_valid !== 1'b1 || held !== e) begin
      failures++; $display("FAIL hold_result got valid=%b res=%0d exp 1 %0d", result_valid, held, e); end
    checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL auto_overrun got=%b exp=1", overrun); end
    auto_en = 0; sys_clk = 0; result_ready = 1;
    step();
    checks++; if (result_valid !== 1'b0) begin failures++; $display("FAIL handshake_clear got=%b exp=0", result_valid); end
    reset = 0; step(); reset = 1; step();
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL overrun_reset got=%b exp=0", overrun); end
  endtask

  task automatic test_busy_drop();
    run_conv(777, 0, 10);
    checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL busy_overrun got=%b exp=1", overrun); end
    checks++; if (busy !== 1'b0 || sb.size() != 0) begin
      failures++; $display("FAIL busy_extra got busy=%b q=%0d exp 0 0", busy, sb.size()); end
    reset = 0; step(); reset = 1; step();
  endtask

  task automatic test_reset_abort();
    bit seen = 0;
    vin = 10'd341; start = 1;
    step(); start = 0;
    repeat (10) step();
    checks++; if (dac_code !== 10'd352) begin failures++; $display("FAIL abort_bit5_dac got=%0d exp=352", dac_code); end
    reset = 0;
    step();
    checks++; if (busy !== 1'b0 || dac_code !== 10'd0 || result_valid !== 1'b0 || sample_en !== 1'b0) begin
      failures++; $display("FAIL abort_state got busy=%b dac=%0d valid=%b exp 0 0 0", busy, dac_code, result_valid); end
    reset = 1;
    repeat (30) begin step(); if (result_valid) seen = 1; end
    checks++; if (seen) begin failures++; $display("FAIL abort_no_result got valid seen exp none"); end
    run_conv(600, 0, 0);
  endtask

  task automatic test_small();
    int n;
    logic [5:0] e;
    vin2 = 6'd37; start2 = 1; sb2.push_back(6'd37);
    step(); start2 = 0; n = 1;
    while (!valid2 && n < 100) begin step(); n++; end
    checks++;
    if (!valid2) begin failures++; $display("FAIL small_timeout got no result exp result");
    end else begin
      e = sb2.pop_front();
      if (result2 !== e) begin failures++; $display("FAIL small_result got=%0d exp=%0d", result2, e); end
      checks++; if (n != 8) begin failures++; $display("FAIL small_latency got=%0d exp=8", n); end
    end
    step();
  endtask

  initial begin
    test_reset();
    test_codes();
    test_auto();
    test_busy_drop();
    test_reset_abort();
    test_small();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
